// File: rtl/tdm_pkg.sv
// Shared constants and types for the two-channel TDM demultiplexer.
package tdm_pkg;

  localparam int TDM_WIDTH_DEF = 8;

  typedef enum logic {
    FILL = 1'b0,
    LAST = 1'b1
  } chan_state_e;

  localparam int PRB_W     = 9;
  localparam int PRB_DIN   = 0;
  localparam int PRB_SEL   = 1;
  localparam int PRB_DVLD  = 2;
  localparam int PRB_V0    = 3;
  localparam int PRB_V1    = 4;
  localparam int PRB_OVR0  = 5;
  localparam int PRB_OVR1  = 6;
  localparam int PRB_LAST0 = 7;
  localparam int PRB_LAST1 = 8;

endpackage

// File: rtl/tdm_demux_chan.sv
// One demux channel: LSB-first word assembly, holding register with
// valid/ready handshake and sticky overrun flag.
module tdm_demux_chan
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic             d,
  input  logic             clr_ovr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             ovr
`ifdef TDM_DEMUX_PROBE_EN
  ,
  output logic             vld_nxt,
  output logic             ovr_nxt,
  output logic             last_nxt
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 2);

  chan_state_e      state_p0, state_d;
  logic [CW-1:0]    cnt_p0, cnt_d;
  logic [WIDTH-1:0] sh_p0, sh_d;
  logic [WIDTH-1:0] hold_p1, hold_d;
  logic             vld_p1, vld_d;
  logic             ovr_p1, ovr_d;
  logic [WIDTH-1:0] word;
  logic             done, xfer, overrun;

  assign word    = {d, sh_p0[WIDTH-1:1]};
  assign done    = acc && (state_p0 == LAST);
  assign xfer    = done && (!vld_p1 || out_ready);
  assign overrun = done && vld_p1 && !out_ready;

  always_comb begin
    state_d = state_p0;
    cnt_d   = cnt_p0;
    sh_d    = sh_p0;
    hold_d  = hold_p1;
    vld_d   = vld_p1;
    ovr_d   = ovr_p1;
    if (acc) begin
      sh_d = word;
      unique case (state_p0)
        FILL: begin
          cnt_d = cnt_p0 + CW'(1);
          if (cnt_p0 == CNT_PRE_LAST) state_d = LAST;
        end
        LAST: begin
          cnt_d   = '0;
          state_d = FILL;
        end
      endcase
    end
    if (vld_p1 && out_ready) vld_d = 1'b0;
    // a transfer in the consume cycle keeps valid high with the new word
    if (xfer) begin
      hold_d = word;
      vld_d  = 1'b1;
    end
    if (clr_ovr) ovr_d = 1'b0;
    if (overrun) ovr_d = 1'b1;
  end

  // p0: assembly state, p1: holding register and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0 <= FILL;
      cnt_p0   <= '0;
      sh_p0    <= '0;
      hold_p1  <= '0;
      vld_p1   <= 1'b0;
      ovr_p1   <= 1'b0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      sh_p0    <= sh_d;
      hold_p1  <= hold_d;
      vld_p1   <= vld_d;
      ovr_p1   <= ovr_d;
    end
  end

  assign out       = hold_p1;
  assign out_valid = vld_p1;
  assign ovr       = ovr_p1;

`ifdef TDM_DEMUX_PROBE_EN
  assign vld_nxt  = vld_d;
  assign ovr_nxt  = ovr_d;
  assign last_nxt = (state_d == LAST);
`endif

endmodule

// File: rtl/tdm_demux.sv
// Two-channel serial TDM demultiplexer. Define TDM_DEMUX_PROBE_EN to add
// the registered 9-bit debug bus "probe".
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             sel,
  input  logic             d_valid,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             out0_valid,
  output logic             out1_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic             ovr0,
  output logic             ovr1
`ifdef TDM_DEMUX_PROBE_EN
  ,
  output logic [PRB_W-1:0] probe
`endif
);

  logic acc0, acc1;

  assign acc0 = d_valid && !sel;
  assign acc1 = d_valid && sel;

`ifdef TDM_DEMUX_PROBE_EN
  logic vld0_nxt, vld1_nxt, ovr0_nxt, ovr1_nxt, last0_nxt, last1_nxt;
`endif

  tdm_demux_chan #(.WIDTH(WIDTH)) u_ch0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc       (acc0),
    .d         (d_in),
    .clr_ovr   (clr_ovr),
    .out_ready (out0_ready),
    .out       (out0),
    .out_valid (out0_valid),
    .ovr       (ovr0)
`ifdef TDM_DEMUX_PROBE_EN
    ,
    .vld_nxt   (vld0_nxt),
    .ovr_nxt   (ovr0_nxt),
    .last_nxt  (last0_nxt)
`endif
  );

  tdm_demux_chan #(.WIDTH(WIDTH)) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc       (acc1),
    .d         (d_in),
    .clr_ovr   (clr_ovr),
    .out_ready (out1_ready),
    .out       (out1),
    .out_valid (out1_valid),
    .ovr       (ovr1)
`ifdef TDM_DEMUX_PROBE_EN
    ,
    .vld_nxt   (vld1_nxt),
    .ovr_nxt   (ovr1_nxt),
    .last_nxt  (last1_nxt)
`endif
  );

`ifdef TDM_DEMUX_PROBE_EN
  // status bits use next-state values so they line up with the channel regs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      probe <= '0;
    end else begin
      probe[PRB_DIN]   <= d_in;
      probe[PRB_SEL]   <= sel;
      probe[PRB_DVLD]  <= d_valid;
      probe[PRB_V0]    <= vld0_nxt;
      probe[PRB_V1]    <= vld1_nxt;
      probe[PRB_OVR0]  <= ovr0_nxt;
      probe[PRB_OVR1]  <= ovr1_nxt;
      probe[PRB_LAST0] <= last0_nxt;
      probe[PRB_LAST1] <= last1_nxt;
    end
  end
`endif

endmodule
